motor_pwm_bank: RTL

MOTOR_PWM_BANK -- requirements
Module: motor_pwm_bank

---
 rtl/motor_pwm_pkg.sv | 15 +
 rtl/motor_pwm_bank_if.sv | 26 ++
 rtl/motor_pwm_bank_channel.sv | 73 +++++++
 rtl/motor_pwm_bank.sv | 80 ++++++++
 4 files changed

// File: rtl/motor_pwm_pkg.sv
// Shared widths, limits and the duty clamp helper for the motor PWM bank.
package motor_pwm_pkg;

    localparam int DUTY_W   = 7;
    localparam int DUTY_MAX = 100;
    localparam int CH_W     = 3;

    typedef logic [DUTY_W-1:0] duty_t;
    typedef logic [CH_W-1:0]   ch_t;

    function automatic duty_t clamp_duty(input duty_t duty);
        return (duty > duty_t'(DUTY_MAX)) ? duty_t'(DUTY_MAX) : duty;
    endfunction

endpackage

// File: rtl/motor_pwm_bank_if.sv
// Duty command channel: valid/ready handshake plus the invalid-channel error pulse.
interface motor_pwm_bank_if;

    logic                  cmd_valid;
    logic                  cmd_ready;
    motor_pwm_pkg::ch_t    cmd_ch;
    motor_pwm_pkg::duty_t  cmd_duty;
    logic                  cmd_err;

    modport master (
        output cmd_valid,
        output cmd_ch,
        output cmd_duty,
        input  cmd_ready,
        input  cmd_err
    );

    modport slave (
        input  cmd_valid,
        input  cmd_ch,
        input  cmd_duty,
        output cmd_ready,
        output cmd_err
    );

endinterface

// File: rtl/motor_pwm_bank_channel.sv
// One PWM channel: target/current duty, boundary update and registered compare output.
// Defining RAMP_EN makes the current duty slew toward the target by RAMP_STEP per period.
module pwm_channel
    import motor_pwm_pkg::*;
#(
    parameter int TICKS_PER_PCT = 1000,
    parameter int CNT_W         = 17
`ifdef RAMP_EN
    ,
    parameter int RAMP_STEP     = 5
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             boundary,
    input  logic             wr,
    input  duty_t            wr_duty,
    input  logic [CNT_W-1:0] count,
    output logic             pwm,
    output logic             ramping
);

    localparam int PERIOD = 100 * TICKS_PER_PCT;
    // Threshold must hold PERIOD itself so that 100% never wraps to a short compare.
    localparam int TH_W   = $clog2(PERIOD + 1);

    duty_t            target_reg;
    duty_t            cur_reg;
    duty_t            cur_next;
    logic             pwm_reg;
    logic [TH_W-1:0]  thresh;

    assign thresh = TH_W'(cur_reg) * TH_W'(TICKS_PER_PCT);

`ifdef RAMP_EN
    localparam duty_t STEP = duty_t'(RAMP_STEP);

    always_comb begin
        cur_next = cur_reg;
        if (cur_reg < target_reg) begin
            cur_next = (target_reg - cur_reg > STEP) ? cur_reg + STEP : target_reg;
        end else if (cur_reg > target_reg) begin
            cur_next = (cur_reg - target_reg > STEP) ? cur_reg - STEP : target_reg;
        end
    end
`else
    always_comb begin
        cur_next = target_reg;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            target_reg <= '0;
            cur_reg    <= '0;
            pwm_reg    <= 1'b0;
        end else begin
            if (wr) begin
                target_reg <= wr_duty;
            end
            // Current duty only moves on the wrap cycle so a period never glitches.
            if (boundary) begin
                cur_reg <= cur_next;
            end
            pwm_reg <= en && (TH_W'(count) < thresh);
        end
    end

    assign pwm     = pwm_reg;
    assign ramping = (cur_reg != target_reg);

endmodule

// File: rtl/motor_pwm_bank.sv
// Bank of N_CH PWM channels sharing one period counter and a duty command port.
// Optional soft start/stop is enabled by defining RAMP_EN.
module motor_pwm_bank
    import motor_pwm_pkg::*;
#(
    parameter int N_CH          = 2,
    parameter int TICKS_PER_PCT = 1000,
    parameter int RAMP_STEP     = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    motor_pwm_bank_if.slave     cmd,
    output logic [N_CH-1:0]     pwm,
    output logic [N_CH-1:0]     ramping,
    output logic                period_start
);

    localparam int PERIOD  = 100 * TICKS_PER_PCT;
    localparam int CNT_W   = $clog2(PERIOD);
    localparam int CNT_MAX = PERIOD - 1;

    if ((N_CH < 1) || (N_CH > 8) || (RAMP_STEP < 1) || (RAMP_STEP > 100)) begin : g_bad_cfg
        $error("motor_pwm_bank: parameter out of range");
    end

    logic [CNT_W-1:0] count_reg;
    logic             cmd_ready_reg;
    logic             cmd_err_reg;
    logic             boundary;
    logic             accept;
    duty_t            duty_in;

    assign boundary = en && (count_reg == CNT_W'(CNT_MAX));
    assign accept   = cmd.cmd_valid && cmd_ready_reg;
    assign duty_in  = clamp_duty(cmd.cmd_duty);

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg     <= '0;
            cmd_ready_reg <= 1'b0;
            cmd_err_reg   <= 1'b0;
        end else begin
            cmd_ready_reg <= 1'b1;
            cmd_err_reg   <= accept && (32'(cmd.cmd_ch) >= N_CH);
            if (!en || boundary) begin
                count_reg <= '0;
            end else begin
                count_reg <= count_reg + 1'b1;
            end
        end
    end

    assign cmd.cmd_ready = cmd_ready_reg;
    assign cmd.cmd_err   = cmd_err_reg;
    assign period_start  = en && !rst && (count_reg == '0);

    // An out-of-range channel matches no instance, so nothing is written.
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        pwm_channel #(
            .TICKS_PER_PCT (TICKS_PER_PCT),
            .CNT_W         (CNT_W)
`ifdef RAMP_EN
            ,
            .RAMP_STEP     (RAMP_STEP)
`endif
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .en       (en),
            .boundary (boundary),
            .wr       (accept && (cmd.cmd_ch == CH_W'(gi))),
            .wr_duty  (duty_in),
            .count    (count_reg),
            .pwm      (pwm[gi]),
            .ramping  (ramping[gi])
        );
    end

endmodule
